// File: rtl/sap_pkg.sv
// Shared SAP-1 control definitions: opcodes, one-hot T-states and control-word layout.
// Optional JMP support is enabled by defining SAP_JMP_EN.
package sap_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned T_W  = 6;
  localparam int unsigned CW_W = 13;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_JMP = 4'h3;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // One-hot ring positions; all-zero encodes the halted machine.
  typedef enum logic [T_W-1:0] {
    ST_HALT = 6'b000000,
    ST_T1   = 6'b000001,
    ST_T2   = 6'b000010,
    ST_T3   = 6'b000100,
    ST_T4   = 6'b001000,
    ST_T5   = 6'b010000,
    ST_T6   = 6'b100000
  } t_state_e;

  localparam int unsigned CW_CP   = 0;
  localparam int unsigned CW_EP   = 1;
  localparam int unsigned CW_JMP  = 2;
  localparam int unsigned CW_LM_N = 3;
  localparam int unsigned CW_CE_N = 4;
  localparam int unsigned CW_LI_N = 5;
  localparam int unsigned CW_EI_N = 6;
  localparam int unsigned CW_LA_N = 7;
  localparam int unsigned CW_EA   = 8;
  localparam int unsigned CW_SU   = 9;
  localparam int unsigned CW_EU   = 10;
  localparam int unsigned CW_LB_N = 11;
  localparam int unsigned CW_LO_N = 12;

  // Every active-low strobe high, every active-high strobe low.
  localparam logic [CW_W-1:0] CW_INACTIVE = 13'b1_1000_1111_1000;

endpackage

// File: rtl/ring_counter.sv
// Six-position one-hot T-state ring with synchronous clear and a sticky halt.
module ring_counter
  import sap_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  input  logic           halt,
  output logic [T_W-1:0] t_state
);

  t_state_e state;
  t_state_e state_next;

  always_ff @(posedge clk) begin
    state <= state_next;
  end

  // Clear wins over everything; once zero the ring stays zero until cleared.
  always_comb begin
    state_next = ST_HALT;
    if (clr) begin
      state_next = ST_T1;
    end else if (!halt) begin
      case (state)
        ST_T1:   state_next = ST_T2;
        ST_T2:   state_next = ST_T3;
        ST_T3:   state_next = ST_T4;
        ST_T4:   state_next = ST_T5;
        ST_T5:   state_next = ST_T6;
        ST_T6:   state_next = ST_T1;
        default: state_next = ST_HALT;
      endcase
    end
  end

  assign t_state = state;

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control unit: T-state ring plus opcode decoder producing the datapath control word.
// Define SAP_JMP_EN to decode opcode 4'h3 as JMP; otherwise it runs as NOP and jmp stays 0.
module control_sequencer
  import sap_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic [OP_W-1:0] opcode,
  output logic            cp,
  output logic            ep,
  output logic            jmp,
  output logic            lm_n,
  output logic            ce_n,
  output logic            li_n,
  output logic            ei_n,
  output logic            la_n,
  output logic            ea,
  output logic            su,
  output logic            eu,
  output logic            lb_n,
  output logic            lo_n,
  output logic            hlt,
  output logic [T_W-1:0]  t_state
);

  logic [CW_W-1:0] cw;
  logic            halt_req;

  assign halt_req = !clr && (t_state == ST_T4) && (opcode == OP_HLT);

  ring_counter u_ring (
    .clk     (clk),
    .clr     (clr),
    .halt    (halt_req),
    .t_state (t_state)
  );

  // Control word decode; forced inactive while clear is asserted.
  always_comb begin
    cw = CW_INACTIVE;
    if (!clr) begin
      case (t_state)
        ST_T1: begin
          cw[CW_EP]   = 1'b1;
          cw[CW_LM_N] = 1'b0;
        end
        ST_T2: cw[CW_CP] = 1'b1;
        ST_T3: begin
          cw[CW_CE_N] = 1'b0;
          cw[CW_LI_N] = 1'b0;
        end
        ST_T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              cw[CW_EI_N] = 1'b0;
              cw[CW_LM_N] = 1'b0;
            end
            OP_OUT: begin
              cw[CW_EA]   = 1'b1;
              cw[CW_LO_N] = 1'b0;
            end
`ifdef SAP_JMP_EN
            OP_JMP: begin
              cw[CW_EI_N] = 1'b0;
              cw[CW_JMP]  = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        ST_T5: begin
          case (opcode)
            OP_LDA: begin
              cw[CW_CE_N] = 1'b0;
              cw[CW_LA_N] = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              cw[CW_CE_N] = 1'b0;
              cw[CW_LB_N] = 1'b0;
            end
            default: ;
          endcase
        end
        ST_T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            cw[CW_EU]   = 1'b1;
            cw[CW_LA_N] = 1'b0;
            cw[CW_SU]   = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign cp   = cw[CW_CP];
  assign ep   = cw[CW_EP];
  assign jmp  = cw[CW_JMP];
  assign lm_n = cw[CW_LM_N];
  assign ce_n = cw[CW_CE_N];
  assign li_n = cw[CW_LI_N];
  assign ei_n = cw[CW_EI_N];
  assign la_n = cw[CW_LA_N];
  assign ea   = cw[CW_EA];
  assign su   = cw[CW_SU];
  assign eu   = cw[CW_EU];
  assign lb_n = cw[CW_LB_N];
  assign lo_n = cw[CW_LO_N];
  assign hlt  = !clr && (t_state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed test-plan sequence, then random opcodes and clears.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] opcode;
  logic       cp, ep, jmp, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt;
  logic [5:0] t_state;

  control_sequencer dut (
    .clk(clk), .clr(clr), .opcode(opcode),
    .cp(cp), .ep(ep), .jmp(jmp), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n),
    .ei_n(ei_n), .la_n(la_n), .ea(ea), .su(su), .eu(eu), .lb_n(lb_n),
    .lo_n(lo_n), .hlt(hlt), .t_state(t_state)
  );

  always #5 clk = ~clk;

  // Expected word layout: {t_state, hlt, cp, ep, jmp, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n}
  logic [19:0] sb[$];
  int compared   = 0;
  int mismatched = 0;

  // Model: phase 1..6 is T1..T6, 0 is halted, -1 is unknown (before any clear).
  int phase = -1;

  function automatic logic [19:0] expect_word(int ph, logic c, logic [3:0] op);
    logic p_cp, p_ep, p_jmp, p_ea, p_su, p_eu;
    logic p_lm, p_ce, p_li, p_ei, p_la, p_lb, p_lo;
    logic [5:0] ts;
    logic h;
    p_cp = 0; p_ep = 0; p_jmp = 0; p_ea = 0; p_su = 0; p_eu = 0;
    p_lm = 0; p_ce = 0; p_li = 0; p_ei = 0; p_la = 0; p_lb = 0; p_lo = 0;
    ts = (ph == 0) ? 6'd0 : 6'(1 << (ph - 1));
    h  = (ph == 0) && !c;
    if (!c) begin
      if (ph == 1) begin p_ep = 1; p_lm = 1; end
      if (ph == 2) p_cp = 1;
      if (ph == 3) begin p_ce = 1; p_li = 1; end
      if (op == 4'h0) begin
        if (ph == 4) begin p_ei = 1; p_lm = 1; end
        if (ph == 5) begin p_ce = 1; p_la = 1; end
      end
      if (op == 4'h1 || op == 4'h2) begin
        if (ph == 4) begin p_ei = 1; p_lm = 1; end
        if (ph == 5) begin p_ce = 1; p_lb = 1; end
        if (ph == 6) begin p_eu = 1; p_la = 1; p_su = (op == 4'h2); end
      end
      if (op == 4'hE && ph == 4) begin p_ea = 1; p_lo = 1; end
`ifdef SAP_JMP_EN
      if (op == 4'h3 && ph == 4) begin p_ei = 1; p_jmp = 1; end
`endif
    end
    // Active-low pins are the inverse of the "asserted" flags above.
    return {ts, h, p_cp, p_ep, p_jmp, ~p_lm, ~p_ce, ~p_li, ~p_ei, ~p_la,
            p_ea, p_su, p_eu, ~p_lb, ~p_lo};
  endfunction

  function automatic int next_phase(int ph, logic c, logic [3:0] op);
    if (c)                      return 1;
    if (ph <= 0)                return ph;
    if (ph == 4 && op == 4'hF)  return 0;
    if (ph == 6)                return 1;
    return ph + 1;
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, then advance the model.
  task automatic step(input logic c, input logic [3:0] op);
    clr    = c;
    opcode = op;
    if (phase >= 0) sb.push_back(expect_word(phase, c, op));
    @(posedge clk);
    #1;
    phase = next_phase(phase, c, op);
  endtask

  task automatic run_instr(input logic [3:0] op);
    for (int i = 0; i < 6; i++) step(1'b0, op);
  endtask

  initial begin : monitor
    logic [19:0] exp_w, got_w;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        got_w = {t_state, hlt, cp, ep, jmp, lm_n, ce_n, li_n, ei_n, la_n,
                 ea, su, eu, lb_n, lo_n};
        compared++;
        if (got_w !== exp_w) begin
          mismatched++;
          $display("FAIL ctrl_word @%0t opcode=%h clr=%b got=%h expected=%h",
                   $time, opcode, clr, got_w, exp_w);
        end
      end
    end
  end

  initial begin : stimulus
    int wait_cycles;
    logic [3:0] op_cur;
    clr = 1'b1;
    opcode = 4'h0;
    #1;
    step(1'b1, 4'h0);
    step(1'b1, 4'h0);
    run_instr(4'h0);
    run_instr(4'h2);
    run_instr(4'h1);
    run_instr(4'hE);
    run_instr(4'h3);
    for (int i = 0; i < 4; i++) step(1'b0, 4'hF);
    for (int i = 0; i < 20; i++) step(1'b0, 4'($urandom_range(0, 15)));
    step(1'b1, 4'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h1);
    step(1'b1, 4'h1);
    run_instr(4'h1);
    op_cur = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      // opcode may only change outside T4..T6
      if (phase < 4) op_cur = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 39) == 0), op_cur);
    end
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected words left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

SAP-1 control unit: a 6-state one-hot T-state ring counter plus an opcode decoder that drives the control word for the bus-attached datapath registers. Those registers are PC, MAR, RAM, IR, A, B, ALU and OUT. Every fetch/execute cycle takes six clock cycles: T1–T3 fetch, T4–T6 execute. HLT freezes the machine until `clr`. The block sits between the IR opcode nibble and the load/enable pins of every datapath register.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `clr`  in  1  synchronous, active-high reset.
- `opcode`  in  4  IR upper nibble; must be stable from T4 through T6.
- `cp`  out  1  PC increment (active-high).
- `ep`  out  1  PC drives bus (active-high).
- `jmp`  out  1  PC loads from bus (active-high).
- `lm_n`  out  1  MAR load (active-low).
- `ce_n`  out  1  RAM drives bus (active-low).
- `li_n`  out  1  IR load (active-low).
- `ei_n`  out  1  IR low nibble drives bus (active-low).
- `la_n`  out  1  A load (active-low).
- `ea`  out  1  A drives bus (active-high).
- `su`  out  1  ALU subtract select.
- `eu`  out  1  ALU drives bus (active-high).
- `lb_n`  out  1  B load (active-low).
- `lo_n`  out  1  OUT register load (active-low).
- `hlt`  out  1  halted flag.
- `t_state`  out  6  one-hot T-state, bit0 = T1; all-zero when halted.

## Operation
- States: T1 through T6, plus HALT. Normal progression is T1→T2→…→T6→T1.
- Control word is a combinational decode of the current state and `opcode`.
- Any control signal not listed for a state is inactive: active-low outputs = 1, active-high outputs = 0.
- Fetch, common to all opcodes:
  - T1: `ep`, `lm_n`=0.
  - T2: `cp`.
  - T3: `ce_n`=0, `li_n`=0.
- LDA 4'h0:
  - T4: `ei_n`=0, `lm_n`=0.
  - T5: `ce_n`=0, `la_n`=0.
  - T6: idle.
- ADD 4'h1:
  - T4: `ei_n`=0, `lm_n`=0.
  - T5: `ce_n`=0, `lb_n`=0.
  - T6: `eu`, `la_n`=0.
- SUB 4'h2: same as ADD, with `su`=1 in T6 only.
- OUT 4'hE:
  - T4: `ea`, `lo_n`=0.
  - T5, T6: idle.
- HLT 4'hF: T4 is idle, and the next state is HALT instead of T5.
- HALT: `hlt`=1, `t_state`=0, all control inactive. HALT exits only via `clr`.
- Any other opcode executes as NOP: T4–T6 are idle.
- At most one bus driver is active in any state: `ep`, `ce_n`, `ei_n`, `ea`, `eu`.

## Timing
- On a posedge with `clr`=1, the state becomes T1 regardless of current state. This includes mid-instruction resets and HALT.
- While `clr`=1, all control outputs are forced inactive and `hlt`=0. `t_state` shows the registered state, which is T1 after the first reset edge.
- Before the first reset edge, the state is X.
- One T-state lasts exactly one clock cycle.
- Outputs change after the posedge that enters a state. Datapath registers capture on the posedge that leaves it.
- Instruction latency is 6 cycles. HLT reaches HALT 4 cycles after T1.
- `opcode` is sampled combinationally during T4–T6 only. It is don't-care during T1–T3 and HALT.

## Configuration
- `SAP_JMP_EN` defined: opcode 4'h3 = JMP.
  - T4: `ei_n`=0, `jmp`=1.
  - T5, T6: idle.
  - The next fetch uses the new PC.
- `SAP_JMP_EN` undefined:
  - 4'h3 executes as NOP.
  - `jmp` is tied to 0; the port remains present.

## Structure
- Shared package `sap_pkg` holds:
  - opcode constants (`OP_LDA`, `OP_ADD`, `OP_SUB`, `OP_JMP`, `OP_OUT`, `OP_HLT`);
  - one-hot T-state constants;
  - control-word bit indices and the inactive-default control word.
- Sub-module `ring_counter`:
  - 6-bit one-hot, with a sync `clr` that sets it to 6'b000001;
  - `halt` input forces it to 0 and holds it there.
  - The decoder stays in `control_sequencer`.

## Test plan
- Reset: hold `clr`=1 for 2 edges → `t_state`=6'b000001, `hlt`=0, `lm_n`=`li_n`=`la_n`=`lb_n`=`lo_n`=`ce_n`=`ei_n`=1, `cp`=`ep`=`eu`=`ea`=0.
- Release `clr`, `opcode`=4'h0 → T1 `ep`=1,`lm_n`=0; T2 `cp`=1; T3 `ce_n`=`li_n`=0; T4 `ei_n`=`lm_n`=0; T5 `ce_n`=`la_n`=0; T6 idle; 7th cycle `t_state`=6'b000001.
- `opcode`=4'h2 → T5 `lb_n`=0; T6 `eu`=1,`su`=1,`la_n`=0. Repeat with 4'h1 → T6 `su`=0.
- `opcode`=4'hE → T4 `ea`=1,`lo_n`=0. Then 4'hF → after T4, `hlt`=1, `t_state`=0, held for 20 cycles; a `clr` pulse → T1, `hlt`=0.
- Assert `clr` during T5 of ADD → next cycle T1, and `lb_n` never goes low after the reset edge.
- With `SAP_JMP_EN`, `opcode`=4'h3 → T4 `ei_n`=0,`jmp`=1. Without the macro → `jmp` stays 0 for the whole instruction.
